// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative multiply/divide engine for the EX stage.
// MULT/MULTU run a shift-add loop, DIV/DIVU a restoring shift-subtract loop,
// one bit per cycle. The signed ops work on magnitudes and apply the result
// signs in a single FIXUP cycle, so every op has the same fixed latency.
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FIXUP = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int            CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [CW-1:0]    counter;

    // Op[1] selects divide, Op[0] selects unsigned.
    logic             isDivReg;
    logic [WIDTH-1:0] accHi;        // product high half / partial remainder
    logic [WIDTH-1:0] accLo;        // multiplier bits / dividend-then-quotient bits
    logic [WIDTH-1:0] stepOperand;  // multiplicand (MULT) or divisor (DIV) magnitude
    logic [WIDTH-1:0] rawA;         // dividend as presented, for the divide-by-zero result
    logic             negLow;       // negate product / quotient at FIXUP
    logic             negRem;       // negate remainder at FIXUP (dividend was negative)
    logic             zeroDivisor;

    logic             accept;
    logic             isSignedOp;
    logic [WIDTH-1:0] magA;
    logic [WIDTH-1:0] magB;

    logic [WIDTH:0]   addSum;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] nextHi;
    logic [WIDTH-1:0] nextLo;

    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   fixHi;
    logic [WIDTH-1:0]   fixLo;

    assign Busy = (state == RUN) || (state == FIXUP);
    assign Done = (state == DONE);

    // A launch is taken only between ops, and Flush vetoes it.
    assign accept     = ((state == IDLE) || (state == DONE)) && Start && !Flush;
    assign isSignedOp = !Op[0];

    // Operand magnitudes; |most-negative| is its own bit pattern read unsigned.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        magA = OperandA;
        magB = OperandB;
        if (isSignedOp && OperandA[WIDTH-1]) magA = -OperandA;
        if (isSignedOp && OperandB[WIDTH-1]) magB = -OperandB;
    end

    // One iteration of the shift-add or restoring shift-subtract loop.
    always_comb begin
        addSum = {1'b0, accHi} + (accLo[0] ? {1'b0, stepOperand} : '0);
        trial  = {accHi, accLo[WIDTH-1]} - {1'b0, stepOperand};
        nextHi = addSum[WIDTH:1];
        nextLo = {addSum[0], accLo[WIDTH-1:1]};
        if (isDivReg) begin
            if (!trial[WIDTH]) begin
                nextHi = trial[WIDTH-1:0];
                nextLo = {accLo[WIDTH-2:0], 1'b1};
            end else begin
                nextHi = {accHi[WIDTH-2:0], accLo[WIDTH-1]};
                nextLo = {accLo[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Sign fixup of the finished magnitudes, with the divide-by-zero override.
    always_comb begin
        product = {accHi, accLo};
        if (negLow) product = -product;
        fixHi = product[2*WIDTH-1:WIDTH];
        fixLo = product[WIDTH-1:0];
        if (isDivReg) begin
            fixLo = negLow ? -accLo : accLo;
            fixHi = negRem ? -accHi : accHi;
            if (zeroDivisor) begin
                fixHi = rawA;
                fixLo = '1;
            end
        end
    end

    // Control FSM and iteration counter.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (Rst) begin
            state   <= IDLE;
            counter <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    counter <= '0;
                    state   <= accept ? RUN : IDLE;
                end
                RUN: begin
                    counter <= counter + 1'b1;
                    if (Flush)                     state <= IDLE;
                    else if (counter == LAST_ITER) state <= FIXUP;
                end
                FIXUP:   state <= Flush ? IDLE : DONE;
                default: state <= IDLE;
            endcase
        end
    end

    // Working registers: latched at launch, stepped once per RUN cycle.
    always_ff @(posedge Clk) begin
        // NOTE: the working registers are reset too, so a mid-op reset leaves no stale operands behind.
        if (Rst) begin
            isDivReg    <= 1'b0;
            accHi       <= '0;
            accLo       <= '0;
            stepOperand <= '0;
            rawA        <= '0;
            negLow      <= 1'b0;
            negRem      <= 1'b0;
            zeroDivisor <= 1'b0;
        end else if (accept) begin
            isDivReg    <= Op[1];
            accHi       <= '0;
            accLo       <= Op[1] ? magA : magB;
            stepOperand <= Op[1] ? magB : magA;
            rawA        <= OperandA;
            negLow      <= isSignedOp && (OperandA[WIDTH-1] ^ OperandB[WIDTH-1]);
            negRem      <= isSignedOp && Op[1] && OperandA[WIDTH-1];
            zeroDivisor <= Op[1] && (OperandB == '0);
        end else if (state == RUN) begin
            accHi <= nextHi;
            accLo <= nextLo;
        end
    end

    // Architectural results: written only on the FIXUP->DONE edge.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            HiOut     <= '0;
            LoOut     <= '0;
            DivByZero <= 1'b0;
        end else if (accept) begin
            DivByZero <= 1'b0;
        end else if ((state == FIXUP) && !Flush) begin
            HiOut     <= fixHi;
            LoOut     <= fixLo;
            DivByZero <= zeroDivisor;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: scenario tasks with randomized ops checked against a
// plain-arithmetic reference model of {Hi,Lo} and the divide-by-zero flag.
module tb_ex_muldiv_unit;

    localparam int W = 32;
    // Start in cycle 0 (sampled at its closing edge) -> Done in cycle 34.
    localparam int LATENCY = 34;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic         Clk = 1'b0;
    logic         Rst;
    logic         Start;
    logic [1:0]   Op;
    logic [W-1:0] OperandA;
    logic [W-1:0] OperandB;
    logic         Flush;
    logic         Busy;
    logic         Done;
    logic         DivByZero;
    logic [W-1:0] HiOut;
    logic [W-1:0] LoOut;

    int checks = 0;
    int errors = 0;

    ex_muldiv_unit #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Start     (Start),
        .Op        (Op),
        .OperandA  (OperandA),
        .OperandB  (OperandB),
        .Flush     (Flush),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero),
        .HiOut     (HiOut),
        .LoOut     (LoOut)
    );

    always #5 Clk = ~Clk;

    // Reference model: {dbz, hi, lo} from integer arithmetic.
    function automatic logic [2*W:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_MULT:  begin p = sa * sb;              return {1'b0, p}; end
            OP_MULTU: begin p = {32'd0, a} * {32'd0, b}; return {1'b0, p}; end
            OP_DIV: begin
                if (b == 0) return {1'b1, a, {W{1'b1}}};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[W-1:0], q[W-1:0]};
            end
            default: begin
                if (b == 0) return {1'b1, a, {W{1'b1}}};
                return {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    // Present an op for exactly one sampling edge; returns at the negedge after it.
    task automatic do_start(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge Clk);
        Op = op; OperandA = a; OperandB = b; Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
    endtask

    // Count edges until Done is seen (sampled at negedge); bounded.
    task automatic wait_done(output int edges, output bit timedOut);
        edges = 0;
        timedOut = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (Done) begin
                edges = i;
                timedOut = 1'b0;
                break;
            end
        end
    endtask

    // Run one op to completion and compare everything against the model.
    task automatic run_and_check(input string name, input logic [1:0] op,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
        int         edges;
        bit         to;
        logic [2*W:0] exp;
        exp = model(op, a, b);
        do_start(op, a, b);
        checks++;
        if (DivByZero !== 1'b0 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL %s launch: Busy=%b DivByZero=%b, expected Busy=1 DivByZero=0", name, Busy, DivByZero);
        end
        wait_done(edges, to);
        checks++;
        if (to || edges + 1 !== LATENCY) begin
            errors++;
            $display("FAIL %s latency: got %0d (timeout=%b), expected %0d", name, edges + 1, to, LATENCY);
        end
        checks++;
        if ({DivByZero, HiOut, LoOut} !== exp) begin
            errors++;
            $display("FAIL %s result: got dbz=%b hi=%h lo=%h, expected dbz=%b hi=%h lo=%h",
                     name, DivByZero, HiOut, LoOut, exp[2*W], exp[2*W-1:W], exp[W-1:0]);
        end
        @(negedge Clk);
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done pulse: Done=%b Busy=%b one cycle later, expected 0 0", name, Done, Busy);
        end
    endtask

    task automatic test_reset;
        Rst = 1'b1; Start = 1'b0; Flush = 1'b0; Op = '0; OperandA = '0; OperandB = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        checks++;
        if ({Busy, Done, DivByZero, HiOut, LoOut} !== '0) begin
            errors++;
            $display("FAIL reset: Busy=%b Done=%b dbz=%b hi=%h lo=%h, expected all 0",
                     Busy, Done, DivByZero, HiOut, LoOut);
        end
    endtask

    task automatic test_directed;
        logic [2*W:0] spec;
        run_and_check("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        spec = {1'b0, 32'hFFFF_FFFE, 32'h0000_0001};
        checks++;
        if ({DivByZero, HiOut, LoOut} !== spec) begin
            errors++;
            $display("FAIL multu_max const: got hi=%h lo=%h, expected fffffffe 00000001", HiOut, LoOut);
        end
        run_and_check("mult_neg", OP_MULT, -32'sd3, 32'd7);
        checks++;
        if ({HiOut, LoOut} !== {32'hFFFF_FFFF, 32'hFFFF_FFEB}) begin
            errors++;
            $display("FAIL mult_neg const: got hi=%h lo=%h, expected ffffffff ffffffeb", HiOut, LoOut);
        end
        run_and_check("mult_minsq", OP_MULT, 32'h8000_0000, 32'h8000_0000);
        run_and_check("div_neg", OP_DIV, -32'sd7, 32'd2);
        checks++;
        if ({HiOut, LoOut} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
            errors++;
            $display("FAIL div_neg const: got hi=%h lo=%h, expected ffffffff fffffffd", HiOut, LoOut);
        end
        run_and_check("divu_100_7", OP_DIVU, 32'd100, 32'd7);
        run_and_check("div_wrap", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_and_check("divu_zero", OP_DIVU, 32'd5, 32'd0);
        checks++;
        if ({DivByZero, HiOut, LoOut} !== {1'b1, 32'd5, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL divu_zero const: got dbz=%b hi=%h lo=%h, expected 1 5 ffffffff", DivByZero, HiOut, LoOut);
        end
        run_and_check("div_zero_neg", OP_DIV, -32'sd9, 32'd0);
        run_and_check("multu_clears", OP_MULTU, 32'd6, 32'd7);
    endtask

    task automatic test_random;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: a = 32'h8000_0000;
                2: b = 32'($urandom_range(1, 20));
                3: b = -32'($urandom_range(1, 20));
                default: ;
            endcase
            run_and_check($sformatf("rand%0d", i), op, a, b);
        end
    endtask

    task automatic test_flush;
        int edges;
        bit to;
        bit sawDone;
        run_and_check("flush_pre", OP_MULTU, 32'd3, 32'd4);
        do_start(OP_DIV, 32'd1000, 32'd3);
        repeat (8) @(posedge Clk);
        @(negedge Clk);
        Flush = 1'b1;            // sampled by the 10th edge after launch
        @(posedge Clk);
        @(negedge Clk);
        Flush = 1'b0;
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || HiOut !== 32'd0 || LoOut !== 32'd12) begin
            errors++;
            $display("FAIL flush: Busy=%b Done=%b hi=%h lo=%h, expected 0 0 0 c", Busy, Done, HiOut, LoOut);
        end
        sawDone = 1'b0;
        repeat (40) begin
            @(negedge Clk);
            if (Done) sawDone = 1'b1;
        end
        checks++;
        if (sawDone || LoOut !== 32'd12) begin
            errors++;
            $display("FAIL flush_nodone: sawDone=%b lo=%h, expected 0 c", sawDone, LoOut);
        end
        // Start together with Flush while idle is suppressed.
        @(negedge Clk);
        Op = OP_MULTU; OperandA = 32'd2; OperandB = 32'd2; Start = 1'b1; Flush = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0; Flush = 1'b0;
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_start: Busy=%b, expected 0", Busy);
        end
        // Start while busy is dropped; the original op finishes on time.
        do_start(OP_MULTU, 32'd5, 32'd6);
        repeat (4) @(posedge Clk);
        @(negedge Clk);
        Op = OP_DIVU; OperandA = 32'd9; OperandB = 32'd0; Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        wait_done(edges, to);
        checks++;
        if (to || edges + 6 !== LATENCY || {DivByZero, HiOut, LoOut} !== {1'b0, 32'd0, 32'd30}) begin
            errors++;
            $display("FAIL busy_start: latency=%0d timeout=%b dbz=%b hi=%h lo=%h, expected %0d 0 0 0 1e",
                     edges + 6, to, DivByZero, HiOut, LoOut, LATENCY);
        end
        sawDone = 1'b0;
        repeat (40) begin
            @(negedge Clk);
            if (Done || Busy) sawDone = 1'b1;
        end
        checks++;
        if (sawDone) begin
            errors++;
            $display("FAIL busy_start_queue: got a second op, expected none");
        end
    endtask

    task automatic test_back_to_back;
        int           edges;
        bit           to;
        logic [2*W:0] exp1;
        logic [2*W:0] exp2;
        exp1 = model(OP_MULT, 32'hFFFF_FF00, 32'd77);
        exp2 = model(OP_DIVU, 32'd123456, 32'd789);
        @(negedge Clk);
        Op = OP_MULT; OperandA = 32'hFFFF_FF00; OperandB = 32'd77; Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        wait_done(edges, to);
        checks++;
        if (to || {DivByZero, HiOut, LoOut} !== exp1) begin
            errors++;
            $display("FAIL b2b_first: timeout=%b hi=%h lo=%h, expected hi=%h lo=%h",
                     to, HiOut, LoOut, exp1[2*W-1:W], exp1[W-1:0]);
        end
        Op = OP_DIVU; OperandA = 32'd123456; OperandB = 32'd789;
        edges = 0; to = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (i == 1) begin
                Start = 1'b0;
                checks++;
                if (Busy !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_accept: Busy=%b after DONE with Start high, expected 1", Busy);
                end
            end
            if (Done) begin
                edges = i; to = 1'b0;
                break;
            end
        end
        // One DONE->RUN edge plus the usual launch-to-Done edges.
        checks++;
        if (to || edges !== LATENCY) begin
            errors++;
            $display("FAIL b2b_gap: got %0d edges (timeout=%b), expected %0d", edges, to, LATENCY);
        end
        checks++;
        if ({DivByZero, HiOut, LoOut} !== exp2) begin
            errors++;
            $display("FAIL b2b_second: hi=%h lo=%h, expected hi=%h lo=%h",
                     HiOut, LoOut, exp2[2*W-1:W], exp2[W-1:0]);
        end
    endtask

    task automatic test_mid_reset;
        bit sawDone;
        do_start(OP_MULTU, 32'd1234, 32'd5678);
        repeat (18) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b1;              // sampled by the 20th edge after launch
        @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        checks++;
        if ({Busy, Done, DivByZero, HiOut, LoOut} !== '0) begin
            errors++;
            $display("FAIL mid_reset: Busy=%b Done=%b dbz=%b hi=%h lo=%h, expected all 0",
                     Busy, Done, DivByZero, HiOut, LoOut);
        end
        sawDone = 1'b0;
        repeat (40) begin
            @(negedge Clk);
            if (Done || Busy) sawDone = 1'b1;
        end
        checks++;
        if (sawDone) begin
            errors++;
            $display("FAIL mid_reset_idle: activity after reset, expected none");
        end
        run_and_check("post_reset", OP_DIV, 32'd50, -32'sd8);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
